link_control_fsm: RTL and testbench

Parametrised command/response link controller for the inter-board serial link. It issues a command word to the transmitter and collects a fixed-length response from the receiver. A watchdog timer is built in. On timeout it automatically resyncs the link: it sends a reset command, tosses stale receive data, then retries. It sits between game logic (Start/Cmd/Done/Error) and the transmitter/receiver blocks (Send_*/Rec_*/OutValid).

---
 rtl/link_control_fsm.sv | 154 +++++++++++++++
 tb/tb_link_control_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_control_fsm.sv
// Command/response link controller: sends a command, gathers a fixed-length response,
// and on watchdog timeout resyncs the link (reset command, toss stale data) before retrying.
module link_control_fsm #(
    parameter int                 CMD_W          = 4,
    parameter logic [CMD_W-1:0]   RESET_CMD      = CMD_W'(4'hF),
    parameter int                 RESP_WORDS     = 3,
    parameter int                 TIMEOUT_CYCLES = 4096,
    parameter int                 TOSS_CYCLES    = 512,
    parameter int                 MAX_RETRIES    = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CMD_W-1:0] Cmd,
    output logic             Send_en,
    output logic [CMD_W-1:0] Send_Ctrl,
    input  logic             Send_done,
    output logic             Rec_en,
    output logic             Rec_Reset,
    input  logic             OutValid,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [7:0]       Retry_cnt,
    output logic [7:0]       Word_cnt
);

    localparam int MAX_CYC = (TIMEOUT_CYCLES > TOSS_CYCLES) ? TIMEOUT_CYCLES : TOSS_CYCLES;
    localparam int TW      = $clog2(MAX_CYC);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TOSS_LAST = TW'(TOSS_CYCLES - 1);
    localparam logic [7:0]    RESP_N    = 8'(RESP_WORDS);
    localparam logic [7:0]    MAX_R     = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_RECV, S_RESYNC, S_TOSS, S_DONE, S_FAIL
    } state_t;

    state_t           r_state;
    logic [CMD_W-1:0] r_cmd;
    logic [TW-1:0]    r_timer;

    logic [TW-1:0]    w_timer_inc;
    logic [7:0]       w_word_inc;
    logic [7:0]       w_retry_inc;

    // Saturating increments: the timer and both counters stick at all-ones.
    assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + TW'(1);
    assign w_word_inc  = (Word_cnt == 8'hFF) ? Word_cnt : Word_cnt + 8'd1;
    assign w_retry_inc = (Retry_cnt == 8'hFF) ? Retry_cnt : Retry_cnt + 8'd1;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_timer   <= '0;
            Send_en   <= 1'b0;
            Send_Ctrl <= '0;
            Rec_en    <= 1'b0;
            Rec_Reset <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            Retry_cnt <= 8'd0;
            Word_cnt  <= 8'd0;
        end else begin
            Rec_Reset <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_cmd     <= Cmd;
                        Retry_cnt <= 8'd0;
                        Word_cnt  <= 8'd0;
                        Send_en   <= 1'b1;
                        Send_Ctrl <= Cmd;
                        Busy      <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (Send_done) begin
                        Send_en   <= 1'b0;
                        Send_Ctrl <= '0;
                        Rec_en    <= 1'b1;
                        Rec_Reset <= 1'b1;
                        Word_cnt  <= 8'd0;
                        r_timer   <= '0;
                        r_state   <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A word arriving on the last watchdog cycle still counts and cancels the timeout.
                    if (OutValid) begin
                        Word_cnt <= w_word_inc;
                        r_timer  <= '0;
                        if (w_word_inc == RESP_N) begin
                            Rec_en  <= 1'b0;
                            Done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (r_timer == TMO_LAST) begin
                        Rec_en <= 1'b0;
                        if (Retry_cnt < MAX_R) begin
                            Retry_cnt <= w_retry_inc;
                            Send_en   <= 1'b1;
                            Send_Ctrl <= RESET_CMD;
                            r_state   <= S_RESYNC;
                        end else begin
                            Error   <= 1'b1;
                            r_state <= S_FAIL;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_RESYNC: begin
                    if (Send_done) begin
                        Send_en   <= 1'b0;
                        Send_Ctrl <= '0;
                        Rec_en    <= 1'b1;
                        Rec_Reset <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= S_TOSS;
                    end
                end
                S_TOSS: begin
                    // Stale words are dropped; only an unbroken quiet stretch ends the flush.
                    if (OutValid) begin
                        r_timer <= '0;
                    end else if (r_timer == TOSS_LAST) begin
                        Rec_en    <= 1'b0;
                        Send_en   <= 1'b1;
                        Send_Ctrl <= r_cmd;
                        r_state   <= S_SEND;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_DONE, S_FAIL: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_control_fsm.sv
// Directed bench for link_control_fsm: stimulus pushes expected link events into a queue,
// a negedge monitor pops and compares them as the controller produces them.
module tb_link_control_fsm;

    localparam int EV_SEND   = 0;
    localparam int EV_RECRST = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ERR    = 3;

    typedef struct {
        int kind;
        int ctrl;
        int word;
        int retry;
    } ev_t;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [3:0] Cmd;
    logic       Send_en;
    logic [3:0] Send_Ctrl;
    logic       Send_done;
    logic       Rec_en;
    logic       Rec_Reset;
    logic       OutValid;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [7:0] Retry_cnt;
    logic [7:0] Word_cnt;

    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    logic prev_send = 1'b0;

    link_control_fsm #(
        .CMD_W(4), .RESET_CMD(4'hF), .RESP_WORDS(3),
        .TIMEOUT_CYCLES(16), .TOSS_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Cmd(Cmd),
        .Send_en(Send_en), .Send_Ctrl(Send_Ctrl), .Send_done(Send_done),
        .Rec_en(Rec_en), .Rec_Reset(Rec_Reset), .OutValid(OutValid),
        .Busy(Busy), .Done(Done), .Error(Error),
        .Retry_cnt(Retry_cnt), .Word_cnt(Word_cnt)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int ctrl, input int word, input int retry);
        ev_t e;
        e.kind = kind; e.ctrl = ctrl; e.word = word; e.retry = retry;
        exp_q.push_back(e);
    endtask

    task automatic got_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        case (kind)
            EV_SEND: begin
                chk("send_ctrl", int'(Send_Ctrl), e.ctrl);
                chk("send_retry", int'(Retry_cnt), e.retry);
            end
            EV_DONE: begin
                chk("done_words", int'(Word_cnt), e.word);
                chk("done_retry", int'(Retry_cnt), e.retry);
            end
            EV_ERR: chk("err_retry", int'(Retry_cnt), e.retry);
            default: ;
        endcase
        $display("event kind=%0d ctrl=%0h words=%0d retry=%0d t=%0t",
                 kind, Send_Ctrl, Word_cnt, Retry_cnt, $time);
    endtask

    always @(negedge Clock) begin
        if (Send_en && !prev_send) got_event(EV_SEND);
        prev_send = Send_en;
        if (Rec_Reset) got_event(EV_RECRST);
        if (Done)      got_event(EV_DONE);
        if (Error)     got_event(EV_ERR);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] c);
        Start = 1'b1; Cmd = c;
        tick(1);
        Start = 1'b0;
        chk("start_send_en", int'(Send_en), 1);
        chk("start_ctrl", int'(Send_Ctrl), int'(c));
        chk("start_busy", int'(Busy), 1);
    endtask

    task automatic send_done();
        Send_done = 1'b1;
        tick(1);
        Send_done = 1'b0;
        chk("sd_rec_reset", int'(Rec_Reset), 1);
        chk("sd_send_en", int'(Send_en), 0);
    endtask

    task automatic pulse_ov();
        OutValid = 1'b1;
        tick(1);
        OutValid = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, int'(Busy), 0);
        chk({name, "_outs"}, int'({Send_en, Send_Ctrl, Rec_en, Rec_Reset, Done, Error}), 0);
        chk({name, "_cnts"}, int'({Retry_cnt, Word_cnt}), 0);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Cmd = 4'h0; Send_done = 1'b0; OutValid = 1'b0;

        // 1: reset, then start
        tick(20);
        chk_idle("reset");
        Reset = 1'b1;
        tick(1);
        chk_idle("post_reset");
        push(EV_SEND, 3, 0, 0);
        do_start(4'h3);

        // 2: happy path, words 4 cycles apart
        push(EV_RECRST, 0, 0, 0);
        send_done();
        tick(1);
        chk("rec_reset_one_cycle", int'(Rec_Reset), 0);
        chk("recv_rec_en", int'(Rec_en), 1);
        tick(2);
        pulse_ov();
        tick(3);
        pulse_ov();
        tick(3);
        push(EV_DONE, 0, 3, 0);
        pulse_ov();
        chk("happy_done", int'(Done), 1);
        chk("happy_busy_in_done", int'(Busy), 1);
        tick(1);
        chk("happy_done_drop", int'(Done), 0);
        chk("happy_busy_fall", int'(Busy), 0);
        chk("happy_words_hold", int'(Word_cnt), 3);

        // 3: single timeout, resync, noisy toss, retry
        push(EV_SEND, 3, 0, 0);
        do_start(4'h3);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        tick(15);
        chk("tmo_not_yet", int'(Send_en), 0);
        push(EV_SEND, 15, 0, 1);
        tick(1);
        chk("tmo_resync_ctrl", int'(Send_Ctrl), 15);
        chk("tmo_resync_rec_en", int'(Rec_en), 0);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        for (int k = 0; k < 10; k++) begin
            OutValid = (k % 3 == 0);
            tick(1);
        end
        OutValid = 1'b0;
        chk("toss_words_unchanged", int'(Word_cnt), 0);
        tick(7);
        chk("toss_not_yet", int'(Send_en), 0);
        push(EV_SEND, 3, 0, 1);
        tick(1);
        chk("retry_ctrl", int'(Send_Ctrl), 3);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        push(EV_DONE, 0, 3, 1);
        pulse_ov();
        pulse_ov();
        pulse_ov();
        tick(1);
        chk("retry_idle", int'(Busy), 0);

        // 4: exhaustion
        push(EV_SEND, 5, 0, 0);
        do_start(4'h5);
        for (int r = 0; r < 3; r++) begin
            push(EV_RECRST, 0, 0, 0);
            send_done();
            if (r < 2) begin
                push(EV_SEND, 15, 0, r + 1);
                tick(16);
                push(EV_RECRST, 0, 0, 0);
                send_done();
                push(EV_SEND, 5, 0, r + 1);
                tick(8);
            end else begin
                push(EV_ERR, 0, 0, 2);
                tick(16);
            end
        end
        chk("exh_error", int'(Error), 1);
        chk("exh_retry", int'(Retry_cnt), 2);
        tick(1);
        chk("exh_error_drop", int'(Error), 0);
        chk("exh_idle", int'(Busy), 0);
        chk("exh_retry_hold", int'(Retry_cnt), 2);

        // 5: word on last watchdog cycle, ignored Start, latched Cmd kept
        push(EV_SEND, 6, 0, 0);
        do_start(4'h6);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        tick(15);
        pulse_ov();
        chk("edge_no_resync", int'(Send_en), 0);
        chk("edge_word", int'(Word_cnt), 1);
        Start = 1'b1; Cmd = 4'h9;
        tick(1);
        Start = 1'b0;
        chk("busy_start_ignored", int'(Send_en), 0);
        tick(13);
        chk("timer_reloaded", int'(Send_en), 0);
        tick(1);
        chk("timer_reloaded_15", int'(Send_en), 0);
        push(EV_SEND, 15, 0, 1);
        tick(1);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        push(EV_SEND, 6, 0, 1);
        tick(8);
        chk("latched_cmd_kept", int'(Send_Ctrl), 6);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        push(EV_DONE, 0, 3, 1);
        pulse_ov();
        pulse_ov();
        pulse_ov();
        tick(1);

        // 6: reset mid-receive, final word coincides with reset
        push(EV_SEND, 2, 0, 0);
        do_start(4'h2);
        push(EV_RECRST, 0, 0, 0);
        send_done();
        pulse_ov();
        pulse_ov();
        chk("mid_words", int'(Word_cnt), 2);
        Reset = 1'b0; OutValid = 1'b1;
        tick(1);
        OutValid = 1'b0;
        chk_idle("mid_reset");
        Reset = 1'b1;
        tick(3);
        chk("mid_no_done", int'(Done), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
